// File: rtl/rv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared definitions for the multicycle RISC-V control unit: the FSM state
// enumeration, the major opcode constants and the encodings driven onto the
// datapath select/control lines.
//
// Configuration macro: RV_ITYPE_ALU_EN
//   Defined   -> an EXEC_I state exists for register-immediate ALU ops.
//   Undefined -> no EXEC_I state; OP-IMM instructions are illegal.
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

  // FSM states. The encoding is left to the enum; nothing outside the
  // control unit depends on the numeric values.
  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
`ifdef RV_ITYPE_ALU_EN
    S_EXEC_I,
`endif
    S_ALU_WB,
    S_BRANCH,
    S_TRAP
  } state_t;

  // Major opcodes (IR[6:0]) recognised by the decoder
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;

  // ALU operation encodings
  localparam logic [2:0] ALU_ADD     = 3'b000;
  localparam logic [2:0] ALU_SUB     = 3'b001;
  localparam logic [2:0] ALU_AND     = 3'b010;
  localparam logic [2:0] ALU_OR      = 3'b011;
  localparam logic [2:0] ALU_INVALID = 3'b111;

  // func3 values that map onto a supported ALU operation
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  // Immediate format selection
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;

  // ALU operand A select
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  // Result / writeback select
  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  // Memory address select
  localparam logic ADR_PC      = 1'b0;
  localparam logic ADR_ALU_OUT = 1'b1;

  // True for the two opcodes that go through the address-calculation state
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage : rv_ctrl_pkg

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Translates an instruction's func3 field into the ALU operation code for
// register-register (and, when enabled, register-immediate) instructions.
// Unsupported func3 values produce ALU_INVALID rather than a trap; the
// instruction still retires through the writeback state.
//
// Ports:
//   func3       in  [2:0]  instruction func3 field
//   alu_control out [2:0]  ALU operation (add/and/or or invalid)
// ---------------------------------------------------------------------------
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [2:0] func3,
  output logic [2:0] alu_control
);

  // Only add, or and and are implemented; everything else is flagged
  // invalid so the datapath can recognise it.
  always_comb begin
    alu_control = ALU_INVALID;
    case (func3)
      F3_ADD:  alu_control = ALU_ADD;
      F3_OR:   alu_control = ALU_OR;
      F3_AND:  alu_control = ALU_AND;
      default: alu_control = ALU_INVALID;
    endcase
  end

endmodule : alu_decoder

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore-style control FSM for a multicycle RISC-V datapath. Sequences
// fetch, decode, load/store, register ALU ops and beq, and parks in TRAP
// on any unrecognised opcode until reset.
//
// Configuration macro: RV_ITYPE_ALU_EN
//   Defined   -> OP-IMM (0010011) runs through EXEC_I then ALU_WB.
//   Undefined -> OP-IMM traps like any other unknown opcode.
//
// Ports:
//   clk          in      clock, rising edge
//   rst          in      asynchronous active-high reset
//   op_code      in  [6:0] IR[6:0]
//   func3        in  [2:0] instruction func3
//   func7        in  [6:0] instruction func7 (not needed by this op set)
//   zero         in      ALU result is zero
//   mem_ready    in      memory accepted/completed the current access
//   mem_req      out     memory access request
//   mem_write    out     memory access is a write
//   adr_src      out     memory address select (0=PC, 1=ALUOut)
//   ir_write     out     load instruction register
//   pc_write     out     update program counter
//   reg_write    out     write register file
//   alu_src_a    out [1:0] ALU A select (PC / oldPC / rs1)
//   alu_src_b    out [1:0] ALU B select (rs2 / imm / 4)
//   result_src   out [1:0] result select (ALUOut / mem data / ALU result)
//   imm_type     out [2:0] immediate format (I / S / B)
//   alu_control  out [2:0] ALU operation
//   illegal      out     sticky illegal-instruction flag (TRAP state)
// ---------------------------------------------------------------------------
module multicycle_control
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op_code,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_type,
  output logic [2:0] alu_control,
  output logic       illegal
);

  state_t     state;
  state_t     next_state;
  logic       is_store;
  logic [2:0] func_alu_control;

  // func7 distinguishes add/sub and friends in the full ISA; this op set
  // does not need it, so it is folded into a deliberately unused signal.
  logic unused_func7;
  assign unused_func7 = ^func7;

  alu_decoder u_alu_decoder (
    .func3       (func3),
    .alu_control (func_alu_control)
  );

  // State register. The load/store flavour is captured while decoding so
  // that MEM_ADR's outputs depend on state only, not on the IR bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      is_store <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        is_store <= (op_code == OP_STORE);
      end
    end
  end

  // Next-state and output decode. Every output defaults to zero so each
  // state lists only what it asserts; IDLE and TRAP rely on this.
  always_comb begin
    next_state  = state;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = ADR_PC;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RS2;
    result_src  = RES_ALU_OUT;
    imm_type    = IMM_I;
    alu_control = ALU_ADD;
    illegal     = 1'b0;

    case (state)
      S_IDLE: begin
        next_state = S_FETCH;
      end

      // PC+4 is computed alongside the instruction read; IR and PC are
      // only committed in the cycle the memory completes the access.
      S_FETCH: begin
        mem_req     = 1'b1;
        adr_src     = ADR_PC;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_FOUR;
        alu_control = ALU_ADD;
        result_src  = RES_ALU;
        ir_write    = mem_ready;
        pc_write    = mem_ready;
        if (mem_ready) begin
          next_state = S_DECODE;
        end
      end

      // The branch target (oldPC + B-imm) is computed speculatively here
      // so BRANCH only has to do the comparison.
      S_DECODE: begin
        alu_src_a   = SRC_A_OLD_PC;
        alu_src_b   = SRC_B_IMM;
        imm_type    = IMM_B;
        alu_control = ALU_ADD;
        if (is_mem_op(op_code)) begin
          next_state = S_MEM_ADR;
        end else if (op_code == OP_RTYPE) begin
          next_state = S_EXEC_R;
        end else if (op_code == OP_BRANCH) begin
          next_state = S_BRANCH;
`ifdef RV_ITYPE_ALU_EN
        end else if (op_code == OP_ITYPE) begin
          next_state = S_EXEC_I;
`endif
        end else begin
          next_state = S_TRAP;
        end
      end

      S_MEM_ADR: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_IMM;
        alu_control = ALU_ADD;
        imm_type    = is_store ? IMM_S : IMM_I;
        next_state  = is_store ? S_MEM_WRITE : S_MEM_READ;
      end

      S_MEM_READ: begin
        mem_req = 1'b1;
        adr_src = ADR_ALU_OUT;
        if (mem_ready) begin
          next_state = S_MEM_WB;
        end
      end

      S_MEM_WRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = ADR_ALU_OUT;
        if (mem_ready) begin
          next_state = S_FETCH;
        end
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
        next_state = S_FETCH;
      end

      // Unsupported func3 values still retire via ALU_WB with the invalid
      // ALU code; they are not treated as illegal instructions.
      S_EXEC_R: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_RS2;
        alu_control = func_alu_control;
        next_state  = S_ALU_WB;
      end

`ifdef RV_ITYPE_ALU_EN
      S_EXEC_I: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_IMM;
        imm_type    = IMM_I;
        alu_control = func_alu_control;
        next_state  = S_ALU_WB;
      end
`endif

      S_ALU_WB: begin
        reg_write  = 1'b1;
        result_src = RES_ALU_OUT;
        next_state = S_FETCH;
      end

      // rs1 - rs2 sets zero; ALUOut still holds the target from DECODE.
      S_BRANCH: begin
        alu_src_a   = SRC_A_RS1;
        alu_src_b   = SRC_B_RS2;
        alu_control = ALU_SUB;
        result_src  = RES_ALU_OUT;
        pc_write    = zero;
        next_state  = S_FETCH;
      end

      S_TRAP: begin
        illegal    = 1'b1;
        next_state = S_TRAP;
      end

      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

endmodule : multicycle_control
